// File: rtl/mux_scan_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mux_scan_pkg
//  Description : Shared definitions for the mux-scan serialiser: data word
//                and select widths, plus the state encoding of the
//                serialiser FSM. The PAR state exists only when
//                MUX_SCAN_PARITY_EN is defined.
//  Revision    : 1.0  initial release
// ============================================================================
package mux_scan_pkg;

    localparam int WORD_W = 16;
    localparam int SEL_W  = 4;

    // FSM state encoding (explicit 2-bit width, legacy-compatible constants)
    typedef logic [1:0] state_t;

    localparam state_t IDLE  = 2'd0;
    localparam state_t SHIFT = 2'd1;
`ifdef MUX_SCAN_PARITY_EN
    localparam state_t PAR   = 2'd2;
`endif

    // First select value of a frame for the chosen scan direction
    function automatic logic [SEL_W-1:0] sel_start(input logic lsb_first);
        return lsb_first ? {SEL_W{1'b0}} : {SEL_W{1'b1}};
    endfunction

    // Final data-bit select value of a frame for the chosen scan direction
    function automatic logic [SEL_W-1:0] sel_end(input logic lsb_first);
        return lsb_first ? {SEL_W{1'b1}} : {SEL_W{1'b0}};
    endfunction

endpackage : mux_scan_pkg
`default_nettype wire

// File: rtl/mux_16to1.sv
`default_nettype none
// ============================================================================
//  Module      : mux_16to1
//  Description : Plain 16:1 bit multiplexer, out = in[sel].
//  Ports       : in   [15:0]  data inputs
//                sel  [3:0]   select
//                out          selected bit
//  Revision    : 1.0  initial release
// ============================================================================
module mux_16to1
    import mux_scan_pkg::*;
(
    input  logic [WORD_W-1:0] in,
    input  logic [SEL_W-1:0]  sel,
    output logic              out
);

    assign out = in[sel];

endmodule : mux_16to1
`default_nettype wire

// File: rtl/mux_scan_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : mux_scan_serializer
//  Description : Accepts a 16-bit word on a valid/ready handshake and emits
//                it one bit per transfer by scanning a registered mux select
//                across the registered word. Downstream flow control uses
//                ser_valid/ser_ready; ser_first/ser_last frame the output.
//  Parameters  : LSB_FIRST  1 = scan sel 0..15, 0 = scan sel 15..0
//  Macro       : MUX_SCAN_PARITY_EN  when defined, appends an even-parity
//                bit (state PAR) so a frame is 17 transfers long;
//                otherwise a frame is exactly 16 transfers.
//  Ports       : clk        clock, rising edge
//                rst        synchronous active-high reset
//                in_data    parallel word to serialise
//                in_valid   in_data valid
//                in_ready   block can accept a word (IDLE only)
//                ser_out    current serial bit
//                ser_valid  ser_out valid
//                ser_ready  downstream takes ser_out this cycle
//                ser_first  first bit of a frame
//                ser_last   final bit of a frame
//                sel_dbg    current mux select
//  Revision    : 1.0  initial release
// ============================================================================
module mux_scan_serializer
    import mux_scan_pkg::*;
#(
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              ser_out,
    output logic              ser_valid,
    input  logic              ser_ready,
    output logic              ser_first,
    output logic              ser_last,
    output logic [SEL_W-1:0]  sel_dbg
);

    localparam logic [SEL_W-1:0] c_sel_start = sel_start(LSB_FIRST);
    localparam logic [SEL_W-1:0] c_sel_end   = sel_end(LSB_FIRST);

    state_t             r_state;
    logic [WORD_W-1:0]  r_word;
    logic [SEL_W-1:0]   r_sel;

    logic               w_mux_bit;
    logic               w_at_start;
    logic               w_at_end;
    logic [SEL_W-1:0]   w_sel_next;
`ifdef MUX_SCAN_PARITY_EN
    logic               w_parity;
`endif

    // ------------------------------------------------------------------
    // Bit selection: registered word and select only, so ser_out never
    // sees in_data combinationally.
    // ------------------------------------------------------------------
    mux_16to1 u_mux (
        .in  (r_word),
        .sel (r_sel),
        .out (w_mux_bit)
    );

    assign w_at_start = (r_sel == c_sel_start);
    assign w_at_end   = (r_sel == c_sel_end);
    assign w_sel_next = LSB_FIRST ? (r_sel + 4'd1) : (r_sel - 4'd1);

`ifdef MUX_SCAN_PARITY_EN
    assign w_parity = ^r_word;
`endif

    // ------------------------------------------------------------------
    // State, word and select registers. The select stops at the last
    // data bit instead of wrapping; it is reloaded on the next accept.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_word  <= '0;
            r_sel   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_word  <= in_data;
                        r_sel   <= c_sel_start;
                        r_state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (ser_ready) begin
                        if (w_at_end) begin
`ifdef MUX_SCAN_PARITY_EN
                            r_state <= PAR;
`else
                            r_state <= IDLE;
`endif
                        end else begin
                            r_sel <= w_sel_next;
                        end
                    end
                end
`ifdef MUX_SCAN_PARITY_EN
                PAR: begin
                    if (ser_ready) begin
                        r_state <= IDLE;
                    end
                end
`endif
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs, all decoded from registered state. ser_out is forced low
    // whenever no bit is being presented.
    // ------------------------------------------------------------------
    always_comb begin
        in_ready  = 1'b0;
        ser_valid = 1'b0;
        ser_out   = 1'b0;
        ser_first = 1'b0;
        ser_last  = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
            end
            SHIFT: begin
                ser_valid = 1'b1;
                ser_out   = w_mux_bit;
                ser_first = w_at_start;
`ifndef MUX_SCAN_PARITY_EN
                ser_last  = w_at_end;
`endif
            end
`ifdef MUX_SCAN_PARITY_EN
            PAR: begin
                ser_valid = 1'b1;
                ser_out   = w_parity;
                ser_last  = 1'b1;
            end
`endif
            default: begin
                in_ready = 1'b0;
            end
        endcase
    end

    assign sel_dbg = r_sel;

endmodule : mux_scan_serializer
`default_nettype wire

// File: tb/tb_mux_scan_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mux_scan_serializer
//  Description : Self-checking bench. Two instances (LSB_FIRST=1 and 0) are
//                driven independently; each accepted word pushes its
//                expected frame into a per-instance queue, and every
//                transferred bit pops and compares bit/first/last/sel.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mux_scan_serializer;

`ifdef MUX_SCAN_PARITY_EN
    localparam int FRAME_LEN = 17;
`else
    localparam int FRAME_LEN = 16;
`endif

    typedef struct packed {
        logic       b;
        logic       first;
        logic       last;
        logic [3:0] sel;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]       rst_v;
    logic [1:0][15:0] in_data_v;
    logic [1:0]       in_valid_v;
    logic [1:0]       in_ready_v;
    logic [1:0]       ser_out_v;
    logic [1:0]       ser_valid_v;
    logic [1:0]       ser_ready_v;
    logic [1:0]       ser_first_v;
    logic [1:0]       ser_last_v;
    logic [1:0][3:0]  sel_dbg_v;

    mux_scan_serializer #(.LSB_FIRST(1'b1)) u_dut_lsb (
        .clk       (clk),
        .rst       (rst_v[0]),
        .in_data   (in_data_v[0]),
        .in_valid  (in_valid_v[0]),
        .in_ready  (in_ready_v[0]),
        .ser_out   (ser_out_v[0]),
        .ser_valid (ser_valid_v[0]),
        .ser_ready (ser_ready_v[0]),
        .ser_first (ser_first_v[0]),
        .ser_last  (ser_last_v[0]),
        .sel_dbg   (sel_dbg_v[0])
    );

    mux_scan_serializer #(.LSB_FIRST(1'b0)) u_dut_msb (
        .clk       (clk),
        .rst       (rst_v[1]),
        .in_data   (in_data_v[1]),
        .in_valid  (in_valid_v[1]),
        .in_ready  (in_ready_v[1]),
        .ser_out   (ser_out_v[1]),
        .ser_valid (ser_valid_v[1]),
        .ser_ready (ser_ready_v[1]),
        .ser_first (ser_first_v[1]),
        .ser_last  (ser_last_v[1]),
        .sel_dbg   (sel_dbg_v[1])
    );

    int   n_cmp = 0;
    int   n_err = 0;
    exp_t q0[$];
    exp_t q1[$];
    logic mon_en = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int q_size(input int k);
        return (k == 0) ? q0.size() : q1.size();
    endfunction

    task automatic q_push(input int k, input exp_t e);
        if (k == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    task automatic q_pop(input int k, output exp_t e);
        if (k == 0) e = q0.pop_front();
        else        e = q1.pop_front();
    endtask

    task automatic q_flush(input int k);
        if (k == 0) q0.delete();
        else        q1.delete();
    endtask

    // Expected frame of a word: instance 0 scans sel 0..15, instance 1 15..0
    task automatic push_frame(input int k, input logic [15:0] d);
        exp_t e;
        int   bi;
        for (int i = 0; i < 16; i++) begin
            bi      = (k == 0) ? i : 15 - i;
            e.b     = d[bi];
            e.sel   = bi[3:0];
            e.first = (i == 0);
            e.last  = (i == 15) && (FRAME_LEN == 16);
            q_push(k, e);
        end
        if (FRAME_LEN == 17) begin
            e.b     = ^d;
            e.sel   = (k == 0) ? 4'd15 : 4'd0;
            e.first = 1'b0;
            e.last  = 1'b1;
            q_push(k, e);
        end
    endtask

    // Monitor: handshake and transfer decisions are taken on the value
    // present just before the next rising edge.
    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("u%0d in_ready", k), in_ready_v[k], q_size(k) == 0);
                chk($sformatf("u%0d ser_valid", k), ser_valid_v[k], q_size(k) != 0);
                if (rst_v[k]) begin
                    q_flush(k);
                end else begin
                    if (ser_valid_v[k] && ser_ready_v[k] && q_size(k) != 0) begin
                        q_pop(k, e);
                        chk($sformatf("u%0d ser_out", k),   ser_out_v[k],   e.b);
                        chk($sformatf("u%0d ser_first", k), ser_first_v[k], e.first);
                        chk($sformatf("u%0d ser_last", k),  ser_last_v[k],  e.last);
                        chk($sformatf("u%0d sel_dbg", k),   sel_dbg_v[k],   e.sel);
                    end
                    if (in_valid_v[k] && in_ready_v[k]) begin
                        push_frame(k, in_data_v[k]);
                    end
                end
            end
        end
    end

    task automatic send_word(input int k, input logic [15:0] d);
        int t = 0;
        in_data_v[k]  = d;
        in_valid_v[k] = 1'b1;
        while (t < 200) begin
            @(negedge clk);
            if (in_ready_v[k]) break;
            t++;
        end
        if (t >= 200) chk($sformatf("u%0d send timeout", k), in_ready_v[k], 1);
        @(posedge clk); #1;
        in_valid_v[k] = 1'b0;
    endtask

    task automatic wait_idle(input int k);
        int t = 0;
        while (t < 400 && !(q_size(k) == 0 && in_ready_v[k])) begin
            @(negedge clk);
            t++;
        end
        if (t >= 400) chk($sformatf("u%0d idle timeout", k), q_size(k), 0);
        @(posedge clk); #1;
    endtask

    task automatic wait_sel(input int k, input logic [3:0] s);
        int t = 0;
        while (t < 100 && !(ser_valid_v[k] && sel_dbg_v[k] == s)) begin
            @(posedge clk); #1;
            t++;
        end
        chk($sformatf("u%0d reach sel", k), sel_dbg_v[k], s);
    endtask

    task automatic run_random(input int k, input int n);
        int   sent  = 0;
        int   guard = 0;
        logic hs;
        while ((sent < n || q_size(k) != 0 || in_valid_v[k]) && guard < 5000) begin
            @(negedge clk);
            hs = in_valid_v[k] && in_ready_v[k];
            @(posedge clk); #1;
            if (hs) begin
                in_valid_v[k] = 1'b0;
                sent++;
            end
            if (!in_valid_v[k] && !hs && sent < n) begin
                in_valid_v[k] = 1'b1;
                in_data_v[k]  = 16'($urandom);
            end
            ser_ready_v[k] = ($urandom_range(0, 3) != 0);
            guard++;
        end
        if (guard >= 5000) chk($sformatf("u%0d random timeout", k), q_size(k), 0);
        ser_ready_v[k] = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic v;
        rst_v       = 2'b11;
        in_valid_v  = 2'b00;
        in_data_v   = '0;
        ser_ready_v = 2'b11;
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("u%0d rst in_ready", k),  in_ready_v[k],  1);
            chk($sformatf("u%0d rst ser_valid", k), ser_valid_v[k], 0);
            chk($sformatf("u%0d rst ser_first", k), ser_first_v[k], 0);
            chk($sformatf("u%0d rst ser_last", k),  ser_last_v[k],  0);
            chk($sformatf("u%0d rst ser_out", k),   ser_out_v[k],   0);
            chk($sformatf("u%0d rst sel_dbg", k),   sel_dbg_v[k],   0);
        end
        rst_v  = 2'b00;
        mon_en = 1'b1;

        // Latency and frame length, LSB first
        in_data_v[0]  = 16'h3f0a;
        in_valid_v[0] = 1'b1;
        @(posedge clk); #1;
        in_valid_v[0] = 1'b0;
        chk("lat ser_valid", ser_valid_v[0], 1);
        chk("lat ser_first", ser_first_v[0], 1);
        chk("lat sel_dbg",   sel_dbg_v[0],   0);
        repeat (FRAME_LEN - 1) @(posedge clk);
        #1;
        chk("end in_ready low", in_ready_v[0], 0);
        chk("end ser_last",     ser_last_v[0], 1);
        @(posedge clk); #1;
        chk("end in_ready high", in_ready_v[0], 1);

        // Same word, MSB first
        send_word(1, 16'h3f0a);
        chk("msb first sel", sel_dbg_v[1], 15);
        wait_idle(1);

`ifdef MUX_SCAN_PARITY_EN
        send_word(0, 16'h0001);
        wait_idle(0);
        send_word(0, 16'h3f0a);
        wait_idle(0);
`endif

        // Stall of three cycles at sel 5
        send_word(0, 16'h3f0a);
        wait_sel(0, 4'd5);
        ser_ready_v[0] = 1'b0;
        v = ser_out_v[0];
        repeat (3) begin
            @(posedge clk); #1;
            chk("stall sel_dbg",   sel_dbg_v[0],   5);
            chk("stall ser_out",   ser_out_v[0],   v);
            chk("stall ser_valid", ser_valid_v[0], 1);
        end
        ser_ready_v[0] = 1'b1;
        wait_idle(0);

        // Reset mid-frame at sel 8
        send_word(0, 16'hc3a5);
        wait_sel(0, 4'd8);
        rst_v[0] = 1'b1;
        @(posedge clk); #1;
        rst_v[0] = 1'b0;
        chk("abort ser_valid", ser_valid_v[0], 0);
        chk("abort in_ready",  in_ready_v[0],  1);
        chk("abort sel_dbg",   sel_dbg_v[0],   0);
        send_word(0, 16'h8001);
        chk("restart sel_dbg",   sel_dbg_v[0],   0);
        chk("restart ser_first", ser_first_v[0], 1);
        wait_idle(0);

        // in_valid held with a new word mid-frame
        in_data_v[1]  = 16'ha5c3;
        in_valid_v[1] = 1'b1;
        begin
            int t = 0;
            while (t < 50) begin
                @(negedge clk);
                if (in_ready_v[1]) break;
                t++;
            end
            @(posedge clk); #1;
            in_data_v[1] = 16'h1234;
            t = 0;
            while (t < 100) begin
                @(negedge clk);
                if (in_ready_v[1]) break;
                t++;
            end
            if (t >= 100) chk("held timeout", in_ready_v[1], 1);
            @(posedge clk); #1;
            in_valid_v[1] = 1'b0;
        end
        wait_idle(1);

        run_random(0, 6);
        wait_idle(0);
        run_random(1, 6);
        wait_idle(1);

        chk("q0 drained", q0.size(), 0);
        chk("q1 drained", q1.size(), 0);
        mon_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_mux_scan_serializer
`default_nettype wire
